// File: rtl/sudoku_pkg.sv
// Shared sudoku checker definitions: grid geometry, FSM states and the BCD digit decoder.
package sudoku_pkg;
  localparam int WIDTH = 9;
  localparam int N     = 3;
  localparam int CELLS = WIDTH * WIDTH;

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} checker_state_t;

  // Digits 1..9 map to bit d-1; blank (0) and illegal codes (10..15) give no bit.
  function automatic logic [WIDTH-1:0] bcd_to_onehot(input logic [3:0] d);
    logic [WIDTH-1:0] oh;
    oh = '0;
    for (int i = 0; i < WIDTH; i++) oh[i] = (d == 4'(i + 1));
    return oh;
  endfunction
endpackage

// File: rtl/sudoku_seen_tracker.sv
// One 9x9 array of seen-digit masks (per row, column or sector); combinational hit lookup,
// single-cycle OR-in update, synchronous clear of the whole array.
module sudoku_seen_tracker
  import sudoku_pkg::*;
(
  input  logic             clk,
  input  logic             rst_L,
  input  logic [3:0]       i_idx,
  input  logic [WIDTH-1:0] i_onehot,
  input  logic             i_wr,
  input  logic             i_clr,
  output logic             o_hit
);
  logic [WIDTH-1:0] r_mask [WIDTH];

  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      if (i_idx == 4'(i)) o_hit = |(r_mask[i] & i_onehot);
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      for (int i = 0; i < WIDTH; i++) r_mask[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < WIDTH; i++) r_mask[i] <= '0;
    end else if (i_wr) begin
      for (int i = 0; i < WIDTH; i++)
        if (i_idx == 4'(i)) r_mask[i] <= r_mask[i] | i_onehot;
    end
  end
endmodule

// File: rtl/sudoku_checker.sv
// Checks an 81-cell row-major digit stream is a legal solved sudoku; verdict one cycle after the
// last accept, cell_ready low while the verdict waits for result_ack. CHECKER_ERR_LOC_EN adds err_row/err_col.
module sudoku_checker
  import sudoku_pkg::*;
(
  input  logic       clk,
  input  logic       rst_L,
  input  logic       cell_valid,
  output logic       cell_ready,
  input  logic [3:0] cell_digit,
  input  logic       flush,
  output logic       result_valid,
  input  logic       result_ack,
  output logic       pass,
  output logic       err_blank,
  output logic       err_range,
  output logic       err_dup,
  output logic [6:0] cell_count
`ifdef CHECKER_ERR_LOC_EN
  ,
  output logic [3:0] err_row,
  output logic [3:0] err_col
`endif
);
  checker_state_t   r_state;
  logic [3:0]       r_row, r_col;
  logic [6:0]       r_count;
  logic             r_blank, r_range, r_dup, r_pass;

  logic             w_accept, w_clr, w_last;
  logic             w_legal, w_is_blank, w_is_range, w_dup_now;
  logic             w_hit_row, w_hit_col, w_hit_sec;
  logic             w_blank_nxt, w_range_nxt, w_dup_nxt;
  logic [WIDTH-1:0] w_onehot;
  logic [3:0]       w_sec;

  assign cell_ready   = (r_state != REPORT);
  assign result_valid = (r_state == REPORT);
  assign pass         = r_pass;
  assign err_blank    = r_blank;
  assign err_range    = r_range;
  assign err_dup      = r_dup;
  assign cell_count   = r_count;

  // flush outranks any accept or acknowledge in the same cycle
  assign w_accept   = cell_valid && cell_ready && !flush;
  assign w_clr      = flush || ((r_state == REPORT) && result_ack);
  assign w_last     = w_accept && (r_count == 7'(CELLS - 1));

  assign w_onehot   = bcd_to_onehot(cell_digit);
  assign w_legal    = |w_onehot;
  assign w_is_blank = (cell_digit == 4'd0);
  assign w_is_range = (cell_digit > 4'(WIDTH));
  assign w_dup_now  = w_legal && (w_hit_row || w_hit_col || w_hit_sec);
  assign w_sec      = 4'((int'(r_row) / N) * N + int'(r_col) / N);

  assign w_blank_nxt = r_blank | (w_accept & w_is_blank);
  assign w_range_nxt = r_range | (w_accept & w_is_range);
  assign w_dup_nxt   = r_dup   | (w_accept & w_dup_now);

  sudoku_seen_tracker u_row_seen (
    .clk(clk), .rst_L(rst_L), .i_idx(r_row), .i_onehot(w_onehot),
    .i_wr(w_accept && w_legal), .i_clr(w_clr), .o_hit(w_hit_row)
  );
  sudoku_seen_tracker u_col_seen (
    .clk(clk), .rst_L(rst_L), .i_idx(r_col), .i_onehot(w_onehot),
    .i_wr(w_accept && w_legal), .i_clr(w_clr), .o_hit(w_hit_col)
  );
  sudoku_seen_tracker u_sector_seen (
    .clk(clk), .rst_L(rst_L), .i_idx(w_sec), .i_onehot(w_onehot),
    .i_wr(w_accept && w_legal), .i_clr(w_clr), .o_hit(w_hit_sec)
  );

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_count <= '0;
      r_blank <= 1'b0;
      r_range <= 1'b0;
      r_dup   <= 1'b0;
      r_pass  <= 1'b0;
    end else if (w_clr) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_count <= '0;
      r_blank <= 1'b0;
      r_range <= 1'b0;
      r_dup   <= 1'b0;
      r_pass  <= 1'b0;
    end else if (w_accept) begin
      r_count <= r_count + 7'd1;
      r_blank <= w_blank_nxt;
      r_range <= w_range_nxt;
      r_dup   <= w_dup_nxt;
      if (r_col == 4'(WIDTH - 1)) begin
        r_col <= '0;
        r_row <= (r_row == 4'(WIDTH - 1)) ? 4'd0 : r_row + 4'd1;
      end else begin
        r_col <= r_col + 4'd1;
      end
      if (w_last) begin
        r_state <= REPORT;
        r_pass  <= ~(w_blank_nxt | w_range_nxt | w_dup_nxt);
      end else if (r_state == IDLE) begin
        r_state <= CHECK;
      end
    end
  end

`ifdef CHECKER_ERR_LOC_EN
  logic [3:0] r_err_row, r_err_col;

  assign err_row = r_err_row;
  assign err_col = r_err_col;

  // 4'hF doubles as "nothing latched yet" since real coordinates stop at 8
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_err_row <= 4'hF;
      r_err_col <= 4'hF;
    end else if (w_clr) begin
      r_err_row <= 4'hF;
      r_err_col <= 4'hF;
    end else if (w_accept && (w_is_blank || w_is_range || w_dup_now) && (r_err_row == 4'hF)) begin
      r_err_row <= r_row;
      r_err_col <= r_col;
    end
  end
`endif
endmodule

// File: tb/tb_sudoku_checker.sv
// Directed plus randomized grids against a cell-by-cell reference model of the sudoku rules.
module tb_sudoku_checker;
  logic       clk = 1'b0;
  logic       rst_L = 1'b0;
  logic       cell_valid = 1'b0;
  logic       cell_ready;
  logic [3:0] cell_digit = 4'd0;
  logic       flush = 1'b0;
  logic       result_valid;
  logic       result_ack = 1'b0;
  logic       pass, err_blank, err_range, err_dup;
  logic [6:0] cell_count;
`ifdef CHECKER_ERR_LOC_EN
  logic [3:0] err_row, err_col;
`endif

  int tests = 0;
  int fails = 0;
  int grid [81];
  bit exp_pass, exp_blank, exp_range, exp_dup;
  int exp_row, exp_col;

  sudoku_checker dut (
    .clk(clk), .rst_L(rst_L), .cell_valid(cell_valid), .cell_ready(cell_ready),
    .cell_digit(cell_digit), .flush(flush), .result_valid(result_valid),
    .result_ack(result_ack), .pass(pass), .err_blank(err_blank),
    .err_range(err_range), .err_dup(err_dup), .cell_count(cell_count)
`ifdef CHECKER_ERR_LOC_EN
    , .err_row(err_row), .err_col(err_col)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic build_valid();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        grid[r*9 + c] = ((r*3 + r/3 + c) % 9) + 1;
  endtask

  task automatic relabel();
    int p [10];
    for (int i = 0; i < 10; i++) p[i] = i;
    for (int i = 9; i >= 2; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 1));
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int k = 0; k < 81; k++) grid[k] = p[grid[k]];
  endtask

  // Reference: a cell errs if blank, out of range, or its digit already appeared
  // earlier in the stream in the same row, column or 3x3 box.
  task automatic model();
    exp_blank = 0; exp_range = 0; exp_dup = 0; exp_row = 15; exp_col = 15;
    for (int k = 0; k < 81; k++) begin
      int r;
      int c;
      bit bad;
      r = k / 9; c = k % 9; bad = 0;
      if (grid[k] == 0) begin exp_blank = 1; bad = 1; end
      else if (grid[k] > 9) begin exp_range = 1; bad = 1; end
      else begin
        for (int j = 0; j < k; j++) begin
          int rj;
          int cj;
          rj = j / 9; cj = j % 9;
          if (grid[j] == grid[k] && (rj == r || cj == c || (rj/3 == r/3 && cj/3 == c/3))) begin
            exp_dup = 1; bad = 1;
          end
        end
      end
      if (bad && exp_row == 15) begin exp_row = r; exp_col = c; end
    end
    exp_pass = !(exp_blank || exp_range || exp_dup);
  endtask

  // Sends cells 0..ncells-1; alt inserts an idle cycle before each cell, ack_mid pulses a stray ack.
  task automatic stream(input int ncells, input bit alt, input bit ack_mid);
    for (int k = 0; k < ncells; k++) begin
      if (alt) begin
        @(negedge clk);
        cell_valid = 1'b0;
        result_ack = 1'b0;
      end
      @(negedge clk);
      cell_valid = 1'b1;
      cell_digit = 4'(grid[k]);
      result_ack = ack_mid && (k == 20);
      if (k == 0 || k == 40 || k == ncells - 1) chk($sformatf("ready_cell%0d", k), 32'(cell_ready), 1);
    end
    @(negedge clk);
    cell_valid = 1'b0;
    result_ack = 1'b0;
  endtask

  task automatic check_verdict(input string tag);
    model();
    chk({tag, "_valid"}, 32'(result_valid), 1);
    chk({tag, "_pass"},  32'(pass), 32'(exp_pass));
    chk({tag, "_blank"}, 32'(err_blank), 32'(exp_blank));
    chk({tag, "_range"}, 32'(err_range), 32'(exp_range));
    chk({tag, "_dup"},   32'(err_dup), 32'(exp_dup));
    chk({tag, "_count"}, 32'(cell_count), 81);
    chk({tag, "_ready"}, 32'(cell_ready), 0);
`ifdef CHECKER_ERR_LOC_EN
    chk({tag, "_erow"}, 32'(err_row), 32'(exp_row));
    chk({tag, "_ecol"}, 32'(err_col), 32'(exp_col));
`endif
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 32'(result_valid), 0);
    chk({tag, "_ready"}, 32'(cell_ready), 1);
    chk({tag, "_count"}, 32'(cell_count), 0);
    chk({tag, "_pass"},  32'(pass), 0);
    chk({tag, "_errs"},  32'({err_blank, err_range, err_dup}), 0);
`ifdef CHECKER_ERR_LOC_EN
    chk({tag, "_eloc"}, 32'({err_row, err_col}), 32'hFF);
`endif
  endtask

  task automatic do_ack(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(result_valid), 1);
      chk({tag, "_hold_pass"}, 32'(pass), 32'(exp_pass));
      chk({tag, "_hold_errs"}, 32'({err_blank, err_range, err_dup}),
          32'({exp_blank, exp_range, exp_dup}));
    end
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check_idle({tag, "_postack"});
  endtask

  initial begin
    #12;
    check_idle("reset");
    @(negedge clk);
    rst_L = 1'b1;

    build_valid();
    stream(81, 0, 0);
    check_verdict("valid");
    do_ack("valid", 0);

    build_valid();
    relabel();
    stream(81, 0, 0);
    check_verdict("relabel");
    do_ack("relabel", 1);

    build_valid();
    grid[0] = 2; grid[1] = 1;
    stream(81, 0, 0);
    check_verdict("swap01");
    do_ack("swap01", 0);

    build_valid();
    grid[4*9 + 4] = grid[4*9 + 5];
    stream(81, 0, 0);
    check_verdict("dup44");
    do_ack("dup44", 0);

    build_valid();
    grid[80] = 0; grid[2*9 + 3] = 12;
    stream(81, 0, 0);
    check_verdict("blankrange");
    do_ack("blankrange", 0);

    build_valid();
    stream(81, 1, 1);
    check_verdict("alt");
    do_ack("alt", 10);
    build_valid();
    grid[9] = grid[0];
    stream(81, 0, 0);
    check_verdict("second");
    do_ack("second", 0);

    build_valid();
    grid[5] = 0;
    stream(40, 0, 0);
    chk("flush_pre_count", 32'(cell_count), 40);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_idle("flush40");
    stream(10, 0, 0);
    cell_valid = 1'b1;
    cell_digit = 4'd0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    cell_valid = 1'b0;
    check_idle("flush_accept");
    build_valid();
    stream(81, 0, 0);
    check_verdict("postflush");
    do_ack("postflush", 0);

    grid[3] = 15;
    stream(60, 0, 0);
    chk("rst_pre_count", 32'(cell_count), 60);
    #2 rst_L = 1'b0;
    #1 check_idle("rst_mid");
    @(negedge clk);
    rst_L = 1'b1;
    build_valid();
    stream(81, 0, 0);
    check_verdict("prerst");
    #2 rst_L = 1'b0;
    #1 check_idle("rst_report");
    @(negedge clk);
    rst_L = 1'b1;
    stream(81, 0, 0);
    check_verdict("postrst");
    do_ack("postrst", 0);

    for (int g = 0; g < 6; g++) begin
      int ncorrupt;
      build_valid();
      relabel();
      ncorrupt = int'($urandom_range(3, 0));
      for (int i = 0; i < ncorrupt; i++) grid[$urandom_range(80, 0)] = int'($urandom_range(15, 0));
      stream(81, 1'($urandom_range(1, 0)), 0);
      check_verdict($sformatf("rand%0d", g));
      do_ack($sformatf("rand%0d", g), int'($urandom_range(3, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
